// File: rtl/btn_matrix_scanner.sv
// Row-scanning driver and debouncer for the 5x4 button matrix.
// Drives one row low at a time, samples the synchronized columns at the end
// of each row slot, debounces every key and emits one-cycle press events.
module btn_matrix_scanner #(
    parameter int ROWS           = 5,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ROWS-1:0]      btn_x,
    input  logic [COLS-1:0]      btn_y,
    output logic [ROWS*COLS-1:0] key_state,
    output logic [ROWS*COLS-1:0] key_press,
    output logic                 key_valid,
    output logic [4:0]           key_code
);

    localparam int KEYS  = ROWS * COLS;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROWS-1:0]  btn_x_q, btn_x_d;
    logic [COLS-1:0]  sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q [KEYS];
    logic [CNT_W-1:0] cnt_d [KEYS];
    logic [KEYS-1:0]  key_state_q, key_state_d;
    logic [KEYS-1:0]  key_press_q, key_press_d;
    logic             key_valid_q, key_valid_d;
    logic [4:0]       key_code_q, key_code_d;
    logic             sample_en;

    // Row-slot timer and row pointer; the sample strobe closes each slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        div_d     = div_q + 1'b1;
        row_d     = row_q;
        sample_en = (div_q == DIV_W'(SCAN_DIV - 1));
        if (sample_en) begin
            div_d = '0;
            row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end
        btn_x_d = ~(ROWS'(1) << row_d);
    end

    // Per-key debounce for the row being sampled, plus press-event encoding.
    always_comb begin
        key_state_d = key_state_q;
        key_press_d = '0;
        cnt_d       = cnt_q;
        key_code_d  = '0;
        if (sample_en) begin
            for (int r = 0; r < ROWS; r++) begin
                if (ROW_W'(r) == row_q) begin
                    for (int c = 0; c < COLS; c++) begin
                        // Columns are active-low: a low column means the key is down.
                        if (!sync2_q[c] == key_state_q[r*COLS+c]) begin
                            cnt_d[r*COLS+c] = '0;
                        end else if (cnt_q[r*COLS+c] == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            cnt_d[r*COLS+c]       = '0;
                            key_state_d[r*COLS+c] = !sync2_q[c];
                            key_press_d[r*COLS+c] = !sync2_q[c];
                        end else begin
                            cnt_d[r*COLS+c] = cnt_q[r*COLS+c] + 1'b1;
                        end
                    end
                end
            end
        end
        key_valid_d = |key_press_d;
        // Scan downward so the lowest set index wins.
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (key_press_d[i]) key_code_d = 5'(i);
        end
    end

    // State registers, column synchronizer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            row_q       <= '0;
            btn_x_q     <= ~ROWS'(1);
            sync1_q     <= '1;
            sync2_q     <= '1;
            key_state_q <= '0;
            key_press_q <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            // NOTE: the counter array is real per-key state, so every entry is reset, not left to power-up.
            for (int k = 0; k < KEYS; k++) cnt_q[k] <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
            div_q       <= div_d;
            row_q       <= row_d;
            btn_x_q     <= btn_x_d;
            sync1_q     <= btn_y;
            sync2_q     <= sync1_q;
            key_state_q <= key_state_d;
            key_press_q <= key_press_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            for (int k = 0; k < KEYS; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign btn_x     = btn_x_q;
    assign key_state = key_state_q;
    assign key_press = key_press_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_btn_matrix_scanner.sv
// Directed bench for btn_matrix_scanner with a small matrix model
// (SCAN_DIV=4, DEBOUNCE_SCANS=2). Cycle 0 is the first edge after reset release.
module tb_btn_matrix_scanner;

    localparam int ROWS = 5;
    localparam int COLS = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [ROWS-1:0]      btn_x;
    logic [COLS-1:0]      btn_y;
    logic [ROWS*COLS-1:0] key_state;
    logic [ROWS*COLS-1:0] key_press;
    logic                 key_valid;
    logic [4:0]           key_code;
    logic [ROWS*COLS-1:0] pressed = '0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc;
    int valid_cnt = 0;
    logic [4:0] last_code = '0;
    int base;

    btn_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_x(btn_x), .btn_y(btn_y),
        .key_state(key_state), .key_press(key_press),
        .key_valid(key_valid), .key_code(key_code)
    );

    always #5 clk = ~clk;

    // Matrix model: a column reads low when a pressed key sits on the driven row.
    always_comb begin
        btn_y = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS+c] && !btn_x[r]) btn_y[c] = 1'b0;
    end

    // Edges since reset release: after cycle k's edge, cyc == k+1.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Pulse monitor for key_valid.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            last_code = key_code;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_after(input int k);
        while (cyc < k + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1. Reset values and idle row stepping.
        pressed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_btn_x", 32'(btn_x), 32'h1e);
        chk("rst_state", 32'(key_state), 32'h0);
        chk("rst_press", 32'(key_press), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        base = valid_cnt;
        @(negedge clk);
        rst = 1'b0;
        wait_after(2);  chk("scan_c2", 32'(btn_x), 32'h1e);
        wait_after(3);  chk("scan_c3", 32'(btn_x), 32'h1d);
        wait_after(7);  chk("scan_c7", 32'(btn_x), 32'h1b);
        wait_after(11); chk("scan_c11", 32'(btn_x), 32'h17);
        wait_after(15); chk("scan_c15", 32'(btn_x), 32'h0f);
        wait_after(19); chk("scan_c19", 32'(btn_x), 32'h1e);
        wait_after(60);
        chk("idle_no_valid", 32'(valid_cnt - base), 32'h0);

        // 2. Key (1,0) held from cycle 0.
        pressed = 20'h00010;
        do_reset();
        base = valid_cnt;
        wait_after(26);
        chk("t2_pre_state", 32'(key_state), 32'h0);
        chk("t2_pre_valid", 32'(key_valid), 32'h0);
        wait_after(27);
        chk("t2_valid", 32'(key_valid), 32'h1);
        chk("t2_code", 32'(key_code), 32'h4);
        chk("t2_press", 32'(key_press), 32'h00010);
        chk("t2_state", 32'(key_state), 32'h00010);
        wait_after(28);
        chk("t2_valid_drop", 32'(key_valid), 32'h0);
        chk("t2_press_drop", 32'(key_press), 32'h0);
        wait_after(140);
        chk("t2_one_pulse", 32'(valid_cnt - base), 32'h1);
        chk("t2_held_state", 32'(key_state), 32'h00010);

        // 3. Key (1,0) seen by a single row-1 sample only.
        pressed = '0;
        do_reset();
        base = valid_cnt;
        wait_after(2);
        pressed = 20'h00010;
        wait_after(8);
        pressed = '0;
        wait_after(90);
        chk("t3_state", 32'(key_state), 32'h0);
        chk("t3_no_valid", 32'(valid_cnt - base), 32'h0);

        // 4. Release after debounce: state clears two scans later, no event.
        pressed = 20'h00010;
        do_reset();
        base = valid_cnt;
        wait_after(30);
        chk("t4_pressed", 32'(key_state), 32'h00010);
        pressed = '0;
        wait_after(66);
        chk("t4_still_set", 32'(key_state), 32'h00010);
        wait_after(67);
        chk("t4_cleared", 32'(key_state), 32'h0);
        chk("t4_no_press", 32'(key_press), 32'h0);
        wait_after(100);
        chk("t4_valid_cnt", 32'(valid_cnt - base), 32'h1);

        // 5. Keys (2,1) and (2,3) together.
        pressed = 20'h00A00;
        do_reset();
        base = valid_cnt;
        wait_after(31);
        chk("t5_valid", 32'(key_valid), 32'h1);
        chk("t5_code", 32'(key_code), 32'h9);
        chk("t5_press", 32'(key_press), 32'h00A00);
        chk("t5_state", 32'(key_state), 32'h00A00);
        wait_after(100);
        chk("t5_one_pulse", 32'(valid_cnt - base), 32'h1);

        // 6. Reset pulse while key (0,0) is held and debounced.
        pressed = 20'h00001;
        do_reset();
        base = valid_cnt;
        wait_after(30);
        chk("t6_debounced", 32'(key_state), 32'h00001);
        chk("t6_first_code", 32'(last_code), 32'h0);
        rst = 1'b1;
        #1;
        chk("t6_async_state", 32'(key_state), 32'h0);
        chk("t6_async_btn_x", 32'(btn_x), 32'h1e);
        chk("t6_async_valid", 32'(key_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_after(22);
        chk("t6_redebounce", 32'(key_state), 32'h0);
        wait_after(23);
        chk("t6_valid", 32'(key_valid), 32'h1);
        chk("t6_code", 32'(key_code), 32'h0);
        chk("t6_press", 32'(key_press), 32'h00001);
        wait_after(40);
        chk("t6_pulses", 32'(valid_cnt - base), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
